// File: rtl/pipe_issue_ctrl.sv
// pipe_issue_ctrl: instruction issue controller for the 4-stage pipeline.
// Buffers instruction words in a DEPTH-entry FIFO and issues at most one per
// cycle, stalling on read-after-write hazards against the last HAZ_WIN issued
// destination registers. Heads with an illegal func (>11) are dropped.
// Build option: define OPERAND_DECODE_EN to restrict the hazard check to the
// source registers the func actually reads; otherwise rs1 and rs2 are always
// checked.
//
// Handshake: a word transfers on a rising edge where in_valid & in_ready.
// in_ready depends only on registered occupancy (and rst_n), never on the
// same-cycle pop, so it is glitch-free and has no combinational path from
// the issue logic. The issue side has no backpressure: iss_valid is a
// one-cycle strobe per issued word.
module pipe_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int HAZ_WIN = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_rs1,
  input  logic [3:0]                 in_rs2,
  input  logic [3:0]                 in_rd,
  input  logic [3:0]                 in_func,
  input  logic [7:0]                 in_addr,
  output logic                       iss_valid,
  output logic [3:0]                 iss_rs1,
  output logic [3:0]                 iss_rs2,
  output logic [3:0]                 iss_rd,
  output logic [3:0]                 iss_func,
  output logic [7:0]                 iss_addr,
  output logic                       illegal_pulse,
  output logic [15:0]                stall_cnt,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Entry layout: {rs1, rs2, rd, func, addr}
  logic [23:0]         mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [HAZ_WIN-1:0]  trk_valid;
  logic [3:0]          trk_rd [HAZ_WIN];

  logic [23:0] head;
  logic [3:0]  head_rs1, head_rs2, head_rd, head_func;
  logic [7:0]  head_addr;
  logic        empty, head_illegal, hazard;
  logic        use_rs1, use_rs2;
  logic        do_push, do_pop, do_issue, do_stall, do_drop;

  assign head      = mem[rd_ptr];
  assign head_rs1  = head[23:20];
  assign head_rs2  = head[19:16];
  assign head_rd   = head[15:12];
  assign head_func = head[11:8];
  assign head_addr = head[7:0];

  assign empty        = (fifo_level == '0);
  assign head_illegal = (head_func > 4'd11);

  assign in_ready = rst_n & (fifo_level != LW'(DEPTH));
  assign busy     = (fifo_level != '0) | (|trk_valid);

  // Which source operands of the head take part in the hazard check
  always_comb begin
    use_rs1 = 1'b1;
    use_rs2 = 1'b1;
`ifdef OPERAND_DECODE_EN
    case (head_func)
      4'd4, 4'd9:                use_rs1 = 1'b0;
      4'd3, 4'd8, 4'd10, 4'd11:  use_rs2 = 1'b0;
      default: ;
    endcase
`endif
  end

  // RAW hazard: a checked source matches any valid in-flight destination
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) begin
      if (trk_valid[i] &&
          ((use_rs1 && (head_rs1 == trk_rd[i])) ||
           (use_rs2 && (head_rs2 == trk_rd[i]))))
        hazard = 1'b1;
    end
  end

  // Flush overrides both accept and issue
  assign do_push  = in_valid & in_ready & ~flush;
  assign do_drop  = ~flush & ~empty & head_illegal;
  assign do_issue = ~flush & ~empty & ~head_illegal & ~hazard;
  assign do_stall = ~flush & ~empty & ~head_illegal & hazard;
  assign do_pop   = do_drop | do_issue;

  // FIFO storage write; contents need no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {in_rs1, in_rs2, in_rd, in_func, in_addr};
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
    end
  end

  // Issue register: fields hold their last value between issues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid     <= 1'b0;
      iss_rs1       <= '0;
      iss_rs2       <= '0;
      iss_rd        <= '0;
      iss_func      <= '0;
      iss_addr      <= '0;
      illegal_pulse <= 1'b0;
    end else begin
      iss_valid     <= do_issue;
      illegal_pulse <= do_drop;
      if (do_issue) begin
        iss_rs1  <= head_rs1;
        iss_rs2  <= head_rs2;
        iss_rd   <= head_rd;
        iss_func <= head_func;
        iss_addr <= head_addr;
      end
    end
  end

  // Saturating count of cycles the head was held by a hazard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            stall_cnt <= '0;
    else if (do_stall && stall_cnt != '1)  stall_cnt <= stall_cnt + 1'b1;
  end

  // Destination tracker: shifts every edge, entry 0 records this edge's issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_valid <= '0;
      for (int i = 0; i < HAZ_WIN; i++) trk_rd[i] <= '0;
    end else begin
      trk_valid[0] <= do_issue;
      trk_rd[0]    <= do_issue ? head_rd : 4'd0;
      for (int i = 1; i < HAZ_WIN; i++) begin
        trk_valid[i] <= trk_valid[i-1];
        trk_rd[i]    <= trk_rd[i-1];
      end
    end
  end

endmodule
